// File: rtl/shift_pkg.sv
// Shared types for the serial shift datapath (deserializer today, serializer later).
package shift_pkg;

    typedef enum logic {COLLECT = 1'b0, STALL = 1'b1} deser_state_t;

    typedef enum logic {MSB_FIRST = 1'b0, LSB_FIRST = 1'b1} bit_order_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_deserializer_bit_counter.sv
// Wrapping bit counter: counts accepted bits and flags the last position of a frame.
module bit_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] wrap_val,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: advance on inc, return to zero after the wrap value.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            if (count_q == wrap_val) begin
                count_d = {CNT_W{1'b0}};
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = (count_q == wrap_val);

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver with a single-entry output buffer.
// Define SHIFT_DESER_PARITY_EN to append an even-parity bit to each frame and expose parity_err.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             lsb_first,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             overflow
`ifdef SHIFT_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

`ifdef SHIFT_DESER_PARITY_EN
    localparam int CNT_W      = $clog2(WIDTH + 1);
    localparam int FRAME_LAST = WIDTH;
`else
    localparam int CNT_W      = $clog2(WIDTH);
    localparam int FRAME_LAST = WIDTH - 1;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LAST);

    deser_state_t     state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic             dir_lat_q, dir_lat_d;
`ifdef SHIFT_DESER_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    logic [CNT_W-1:0] count_s;
    logic             terminal_s;
    logic             accept_s;
    logic             stall_s;
    logic             dir_s;
    logic [WIDTH-1:0] shifted_s;

    bit_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .clear    (clear),
        .inc      (accept_s),
        .wrap_val (LAST_IDX),
        .count    (count_s),
        .terminal (terminal_s)
    );

    assign stall_s  = terminal_s && out_valid_q && !out_ready;
    assign accept_s = in_valid && in_ready;

    // Ready: while stalled, only a draining consumer frees the last frame slot.
    always_comb begin
        if (state_q == STALL) begin
            in_ready = out_ready;
        end else begin
            in_ready = !stall_s;
        end
    end

    // Bit order is sampled on the first bit so mid-word changes cannot corrupt a word.
    always_comb begin
        if (count_s == {CNT_W{1'b0}}) begin
            dir_s = lsb_first;
        end else begin
            dir_s = dir_lat_q;
        end
        if (dir_s == LSB_FIRST) begin
            shifted_s = {in_bit, shreg_q[WIDTH-1:1]};
        end else begin
            shifted_s = {shreg_q[WIDTH-2:0], in_bit};
        end
    end

    // Next-state for shift register, output buffer, FSM and sticky overflow.
    always_comb begin
        state_d     = stall_s ? STALL : COLLECT;
        shreg_d     = shreg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        dir_lat_d   = dir_lat_q;
        overflow_d  = overflow_q | (in_valid & ~in_ready);
`ifdef SHIFT_DESER_PARITY_EN
        parity_err_d = parity_err_q;
`endif

        if (accept_s && (count_s == {CNT_W{1'b0}})) begin
            dir_lat_d = lsb_first;
        end else begin
            dir_lat_d = dir_lat_q;
        end

`ifdef SHIFT_DESER_PARITY_EN
        if (accept_s && !terminal_s) begin
            shreg_d = shifted_s;
        end else begin
            shreg_d = shreg_q;
        end
        if (accept_s && terminal_s) begin
            out_data_d   = shreg_q;
            parity_err_d = (^shreg_q) ^ in_bit;
            out_valid_d  = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
`else
        if (accept_s) begin
            shreg_d = shifted_s;
        end else begin
            shreg_d = shreg_q;
        end
        if (accept_s && terminal_s) begin
            out_data_d  = shifted_s;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
`endif
    end

    // State registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= COLLECT;
            shreg_q     <= {WIDTH{1'b0}};
            out_data_q  <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            dir_lat_q   <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            dir_lat_q   <= dir_lat_d;
`ifdef SHIFT_DESER_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;
`ifdef SHIFT_DESER_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed self-checking bench for shift_deserializer (parity cases when SHIFT_DESER_PARITY_EN is defined).
module tb_shift_deserializer;

    localparam int WIDTH = 8;
`ifdef SHIFT_DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             clear;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             lsb_first;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             overflow;
`ifdef SHIFT_DESER_PARITY_EN
    logic             parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    shift_deserializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .lsb_first (lsb_first),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow)
`ifdef SHIFT_DESER_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Bit idx of a frame carrying d; index WIDTH is the even-parity bit.
    function automatic logic frame_bit(input logic [WIDTH-1:0] d, input logic lsb, input int idx);
        if (idx >= WIDTH) return ^d;
        else if (lsb) return d[idx];
        else return d[WIDTH-1-idx];
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] d, input logic lsb, input int n);
        for (int i = 0; i < n; i++) send_bit(frame_bit(d, lsb, i));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clear = 1'b1; in_valid = 1'b0; in_bit = 1'b0; lsb_first = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %0b want 0", out_valid); n_fail++; end
        n_checks++; if (out_data !== 8'h00) begin $display("FAIL reset_out_data got %h want 00", out_data); n_fail++; end
        n_checks++; if (overflow !== 1'b0) begin $display("FAIL reset_overflow got %0b want 0", overflow); n_fail++; end
        n_checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %0b want 1", in_ready); n_fail++; end
`ifdef SHIFT_DESER_PARITY_EN
        n_checks++; if (parity_err !== 1'b0) begin $display("FAIL reset_parity_err got %0b want 0", parity_err); n_fail++; end
`endif
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_msb_first;
        lsb_first = 1'b0; out_ready = 1'b1;
        send_bits(8'h80, 1'b0, FRAME - 1);
        n_checks++; if (out_valid !== 1'b0) begin $display("FAIL msb_early_valid got %0b want 0", out_valid); n_fail++; end
        send_bit(frame_bit(8'h80, 1'b0, FRAME - 1));
        n_checks++; if (out_valid !== 1'b1) begin $display("FAIL msb_valid got %0b want 1", out_valid); n_fail++; end
        n_checks++; if (out_data !== 8'h80) begin $display("FAIL msb_data got %h want 80", out_data); n_fail++; end
        idle(1);
        n_checks++; if (out_valid !== 1'b0) begin $display("FAIL msb_valid_drop got %0b want 0", out_valid); n_fail++; end
        n_checks++; if (out_data !== 8'h80) begin $display("FAIL msb_data_hold got %h want 80", out_data); n_fail++; end
    endtask

    task automatic test_lsb_first;
        lsb_first = 1'b1; out_ready = 1'b1;
        send_bits(8'h01, 1'b1, FRAME);
        n_checks++; if (out_data !== 8'h01 || out_valid !== 1'b1) begin
            $display("FAIL lsb_data got %h/%0b want 01/1", out_data, out_valid); n_fail++; end
        for (int i = 0; i < FRAME; i++) begin
            if (i == 4) lsb_first = 1'b0;
            send_bit(frame_bit(8'h01, 1'b1, i));
        end
        n_checks++; if (out_data !== 8'h01 || out_valid !== 1'b1) begin
            $display("FAIL lsb_toggle_data got %h/%0b want 01/1", out_data, out_valid); n_fail++; end
        lsb_first = 1'b0;
        idle(1);
    endtask

    task automatic test_back_to_back;
        lsb_first = 1'b0; out_ready = 1'b0;
        send_bits(8'hA5, 1'b0, FRAME);
        n_checks++; if (out_data !== 8'hA5 || out_valid !== 1'b1) begin
            $display("FAIL b2b_first got %h/%0b want a5/1", out_data, out_valid); n_fail++; end
        send_bits(8'h3C, 1'b0, FRAME - 1);
        @(negedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin $display("FAIL b2b_stall_ready got %0b want 0", in_ready); n_fail++; end
        @(posedge clk);
        #1;
        n_checks++; if (out_data !== 8'hA5 || out_valid !== 1'b1) begin
            $display("FAIL b2b_held got %h/%0b want a5/1", out_data, out_valid); n_fail++; end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_bit = frame_bit(8'h3C, 1'b0, FRAME - 1);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin $display("FAIL b2b_release_ready got %0b want 1", in_ready); n_fail++; end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++; if (out_data !== 8'h3C || out_valid !== 1'b1) begin
            $display("FAIL b2b_second got %h/%0b want 3c/1", out_data, out_valid); n_fail++; end
        n_checks++; if (overflow !== 1'b0) begin $display("FAIL b2b_overflow got %0b want 0", overflow); n_fail++; end
        idle(1);
        n_checks++; if (out_valid !== 1'b0) begin $display("FAIL b2b_drain got %0b want 0", out_valid); n_fail++; end
    endtask

    task automatic test_overflow;
        lsb_first = 1'b0; out_ready = 1'b0;
        send_bits(8'h55, 1'b0, FRAME);
        send_bits(8'h0F, 1'b0, FRAME - 1);
        @(negedge clk);
        in_valid = 1'b1; in_bit = frame_bit(8'h0F, 1'b0, FRAME - 1);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin $display("FAIL ovf_ready got %0b want 0", in_ready); n_fail++; end
        @(posedge clk);
        #1;
        n_checks++; if (overflow !== 1'b1) begin $display("FAIL ovf_set got %0b want 1", overflow); n_fail++; end
        n_checks++; if (out_data !== 8'h55) begin $display("FAIL ovf_held_data got %h want 55", out_data); n_fail++; end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++; if (out_data !== 8'h0F || out_valid !== 1'b1) begin
            $display("FAIL ovf_second got %h/%0b want 0f/1", out_data, out_valid); n_fail++; end
        idle(3);
        n_checks++; if (overflow !== 1'b1) begin $display("FAIL ovf_sticky got %0b want 1", overflow); n_fail++; end
    endtask

    task automatic test_clear_mid_word;
        lsb_first = 1'b0; out_ready = 1'b1;
        send_bits(8'hC3, 1'b0, FRAME);
        n_checks++; if (out_data !== 8'hC3) begin $display("FAIL clr_pre_data got %h want c3", out_data); n_fail++; end
        send_bits(8'h5A, 1'b0, 5);
        @(negedge clk);
        clear = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            $display("FAIL clr_outputs got %h/%0b want 00/0", out_data, out_valid); n_fail++; end
        n_checks++; if (overflow !== 1'b0) begin $display("FAIL clr_overflow got %0b want 0", overflow); n_fail++; end
        @(negedge clk);
        clear = 1'b0;
        send_bits(8'hFF, 1'b0, FRAME - 1);
        n_checks++; if (out_valid !== 1'b0) begin $display("FAIL clr_early_valid got %0b want 0", out_valid); n_fail++; end
        send_bit(frame_bit(8'hFF, 1'b0, FRAME - 1));
        n_checks++; if (out_data !== 8'hFF || out_valid !== 1'b1) begin
            $display("FAIL clr_clean_word got %h/%0b want ff/1", out_data, out_valid); n_fail++; end
        idle(1);
    endtask

`ifdef SHIFT_DESER_PARITY_EN
    task automatic test_parity;
        lsb_first = 1'b0; out_ready = 1'b1;
        send_bits(8'h81, 1'b0, WIDTH);
        send_bit(1'b0);
        n_checks++; if (out_data !== 8'h81 || out_valid !== 1'b1) begin
            $display("FAIL par_good_data got %h/%0b want 81/1", out_data, out_valid); n_fail++; end
        n_checks++; if (parity_err !== 1'b0) begin $display("FAIL par_good got %0b want 0", parity_err); n_fail++; end
        send_bits(8'h81, 1'b0, WIDTH);
        send_bit(1'b1);
        n_checks++; if (out_data !== 8'h81 || out_valid !== 1'b1) begin
            $display("FAIL par_bad_data got %h/%0b want 81/1", out_data, out_valid); n_fail++; end
        n_checks++; if (parity_err !== 1'b1) begin $display("FAIL par_bad got %0b want 1", parity_err); n_fail++; end
        idle(1);
    endtask
`endif

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_overflow();
        test_clear_mid_word();
`ifdef SHIFT_DESER_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Serial-to-parallel receiver: the far end of the 8-bit shift/rotate datapath, which emits words one bit per cycle.
- Accepts one bit per cycle under a valid/ready handshake and reassembles WIDTH-bit words, MSB-first or LSB-first.
- Presents each completed word on a single-entry output buffer with its own valid/ready handshake.
- Sits between a serial link and the register/mux datapath that consumes parallel words.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-high reset.
- in_valid  input  1  serial bit present.
- in_bit  input  1  serial data bit.
- in_ready  output  1  deserializer accepts in_bit this cycle.
- lsb_first  input  1  word order: 1 = first bit received lands in bit 0; 0 = first bit lands in bit WIDTH-1.
- out_valid  output  1  out_data holds a completed word.
- out_data  output  WIDTH  completed word.
- out_ready  input  1  consumer takes the word this cycle.
- overflow  output  1  sticky: a bit was offered while the block was stalled.

Behaviour:
- Reset: clear is asynchronous and active-high. While clear is high: shreg=0, count=0, state=COLLECT, out_valid=0, out_data=0, overflow=0, dir_lat=0.
- Reset mid-word discards the partial word. Reset with out_valid=1 drops the buffered word.
- Accept event: in_valid && in_ready.
- State COLLECT:
  - in_ready=1 unless count==WIDTH-1 && out_valid && !out_ready.
  - On accept with count==0: latch lsb_first into dir_lat for the whole word. lsb_first changes mid-word are ignored.
  - Shift when dir_lat=0: shreg <= {shreg[WIDTH-2:0], in_bit}.
  - Shift when dir_lat=1: shreg <= {in_bit, shreg[WIDTH-1:1]}.
  - On accept with count<WIDTH-1: count++.
  - On accept with count==WIDTH-1:
    - out_data <= shifted value, out_valid <= 1, count <= 0.
    - Same cycle may also drain the old word (out_ready && out_valid); the new word replaces it with no bubble.
- Stall: count==WIDTH-1 && out_valid && !out_ready.
  - in_ready=0 and state=STALL.
  - STALL -> COLLECT on the cycle out_ready is asserted; in_ready returns to 1 combinationally in that cycle.
- Latency: out_valid rises the cycle after the WIDTH-th bit is accepted.
- Sustained throughput: one word per WIDTH cycles with out_ready held high.
- Output drain: out_valid && out_ready with no new word completing -> out_valid <= 0. out_data holds its last value.
- Overflow: in_valid && !in_ready sets overflow=1. It stays set until clear.
- No bits are dropped; stalled bits are the sender's responsibility to hold.
- in_ready is combinational from state, count, out_valid and out_ready. There is no combinational path from in_bit to any output.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_EN.
- With the macro defined:
  - Each frame is WIDTH data bits followed by one even-parity bit; the counter runs 0..WIDTH.
  - The parity bit is never shifted into shreg.
  - Output port parity_err (1 bit) is valid with out_data. parity_err=1 when XOR of data bits and parity bit is 1.
  - parity_err resets to 0 and updates together with out_data.
  - The stall condition moves to count==WIDTH.
- Without the macro: no parity_err port, frames are exactly WIDTH bits, and the counter wraps at WIDTH-1.

Decomposition:
- Package shift_pkg:
  - typedef enum logic {COLLECT, STALL} deser_state_t.
  - typedef enum logic {MSB_FIRST=0, LSB_FIRST=1} bit_order_t.
  - localparam DEFAULT_WIDTH=8.
- Sub-module bit_counter:
  - Ports: clk, clear, inc, wrap value, count, terminal flag.
  - Instantiated once; reused by the future serializer.
- Shift register, handshake and FSM stay in shift_deserializer.

Test Plan:
- Reset then MSB-first bits 1,0,0,0,0,0,0,0 with out_ready=1 -> out_data=8'h80, out_valid high for 1 cycle, 1 cycle after the 8th bit.
- LSB-first bits 1,0,0,0,0,0,0,0 -> out_data=8'h01. Toggling lsb_first at bit 4 leaves the result at 8'h01.
- Two back-to-back words 8'hA5 then 8'h3C with out_ready=0 -> in_ready=0 at bit 8 of word 2; out_data=8'hA5 held. Raise out_ready -> 8'hA5 taken, 8'h3C appears next cycle; overflow=0.
- Same stall with in_valid held high during the stall -> overflow=1 and stays 1 until clear.
- Assert clear for 1 cycle after bit 5 of a word -> count=0, out_valid=0, out_data=0. The next 8 bits 8'hFF form a clean word 8'hFF.
- SHIFT_DESER_PARITY_EN defined:
  - 8'h81 followed by parity 0 -> parity_err=0.
  - 8'h81 followed by parity 1 -> parity_err=1.
